// File: rtl/vga_timing_pkg.sv
// Raster constants for 640x480@72 shared with the VGA timing generator,
// plus the receiver FSM state encoding and a small counter helper.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_BACK   = 128;
    localparam int H_SYNC   = 40;
    localparam int H_TOTAL  = 832;
    localparam int V_ACTIVE = 480;
    localparam int V_BACK   = 28;
    localparam int V_TOTAL  = 520;

    // Receiver FSM encoding, kept as plain 2-bit constants.
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [9:0] CNT_MAX = 10'h3FF;

    // Increment that sticks at the top value instead of wrapping.
    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_timing_receiver_if.sv
// Link-side and monitor-side signals of the VGA loopback receiver.
// There is no backpressure: the link is a free-running stream in which every
// video_clk edge carries one hsync/vsync/pixel_in sample (implicitly valid,
// never stalled), and every output is a registered per-clock value that the
// consumer must take on the clock it appears.
interface vga_timing_receiver_if;
    logic       hsync;
    logic       vsync;
    logic       pixel_in;
    logic       pixel_out;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       active;
    logic       frame_start;
    logic       locked;
    logic [7:0] lock_loss_cnt;
    logic [1:0] fsm_state;

    // Drives the link (timing generator side), observes the receiver.
    modport master (
        output hsync, vsync, pixel_in,
        input  pixel_out, x_pos, y_pos, active, frame_start, locked,
               lock_loss_cnt, fsm_state
    );

    // The receiver itself.
    modport slave (
        input  hsync, vsync, pixel_in,
        output pixel_out, x_pos, y_pos, active, frame_start, locked,
               lock_loss_cnt, fsm_state
    );
endinterface

// File: rtl/vga_sync_edge.sv
// Falling-edge detector for one active-low sync line.
module vga_sync_edge (
    input  logic video_clk,
    input  logic reset,
    input  logic sync_in,
    output logic fall
);
    logic sync_q;

    // Previous sample; resets to the inactive level so a sync that is already
    // low when reset is released is seen as an edge on the first clock.
    always_ff @(posedge video_clk) begin
        if (reset) sync_q <= 1'b1;
        else       sync_q <= sync_in;
    end

    assign fall = sync_q & ~sync_in;
endmodule

// File: rtl/vga_timing_receiver.sv
// Recovers the raster position from hsync/vsync, verifies line and frame
// lengths, locks after LOCK_FRAMES good frames and emits the pixel with its
// coordinates two clocks after it was sampled.
module vga_timing_receiver #(
    parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int H_BACK      = vga_timing_pkg::H_BACK,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int V_BACK      = vga_timing_pkg::V_BACK,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                   video_clk,
    input  logic                   reset,
    vga_timing_receiver_if.slave   bus
);
    import vga_timing_pkg::*;

    // Visible window in counter units; v_cnt is 0 on the vsync line itself.
    localparam logic [9:0] X_LO   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] X_HI   = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0] Y_LO   = 10'(V_BACK + 1);
    localparam logic [9:0] Y_HI   = 10'(V_BACK + V_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    logic       hs_fall, vs_fall;
    logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic [1:0] state, state_nxt;
    logic [3:0] good_cnt, good_nxt;
    logic [7:0] loss_cnt;
    logic       frame_err, pix_d, loss_inc;
    logic       line_bad, frame_bad, h_stuck;
    logic       vis, act;
    logic [9:0] x_val, y_val;

    vga_sync_edge u_hs_edge (.video_clk(video_clk), .reset(reset), .sync_in(bus.hsync), .fall(hs_fall));
    vga_sync_edge u_vs_edge (.video_clk(video_clk), .reset(reset), .sync_in(bus.vsync), .fall(vs_fall));

    // Next counter values and the line/frame length verdicts for this edge.
    always_comb begin
        h_nxt     = hs_fall ? 10'd0 : sat_inc10(h_cnt);
        v_nxt     = vs_fall ? 10'd0 : (hs_fall ? sat_inc10(v_cnt) : v_cnt);
        h_stuck   = (h_nxt == CNT_MAX);
        line_bad  = hs_fall && (h_cnt != H_LAST);
        frame_bad = vs_fall && ((v_cnt != V_LAST) || frame_err || line_bad);
    end

    // Lock FSM: SEARCH waits for a vsync, VERIFY counts good frames, LOCKED
    // drops on the first bad line, bad frame or runaway line.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        loss_inc  = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (vs_fall) begin
                    state_nxt = ST_VERIFY;
                    good_nxt  = 4'd0;
                end
            end
            ST_VERIFY: begin
                if (h_stuck) begin
                    state_nxt = ST_SEARCH;
                end else if (vs_fall) begin
                    if (frame_bad) begin
                        good_nxt = 4'd0;
                    end else begin
                        good_nxt = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 >= LOCK_N) state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (h_stuck || line_bad || frame_bad) begin
                    state_nxt = ST_SEARCH;
                    loss_inc  = 1'b1;
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    // Sample stage: counters, FSM, sticky line error, loss counter, pixel delay.
    always_ff @(posedge video_clk) begin
        if (reset) begin
            h_cnt     <= 10'd0;
            v_cnt     <= 10'd0;
            state     <= ST_SEARCH;
            good_cnt  <= 4'd0;
            frame_err <= 1'b0;
            loss_cnt  <= 8'd0;
            pix_d     <= 1'b0;
        end else begin
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            state    <= state_nxt;
            good_cnt <= good_nxt;
            pix_d    <= bus.pixel_in;
            if (vs_fall)       frame_err <= 1'b0;
            else if (line_bad) frame_err <= 1'b1;
            if (loss_inc && (loss_cnt != 8'hFF)) loss_cnt <= loss_cnt + 8'd1;
        end
    end

    // Decode position from the registered counters and state.
    always_comb begin
        vis   = (h_cnt >= X_LO) && (h_cnt <= X_HI) && (v_cnt >= Y_LO) && (v_cnt <= Y_HI);
        act   = vis && (state == ST_LOCKED);
        x_val = act ? (h_cnt - X_LO) : 10'd0;
        y_val = act ? (v_cnt - Y_LO) : 10'd0;
    end

    // Output stage: one register after the sample stage.
    always_ff @(posedge video_clk) begin
        if (reset) begin
            bus.pixel_out     <= 1'b0;
            bus.x_pos         <= 10'd0;
            bus.y_pos         <= 10'd0;
            bus.active        <= 1'b0;
            bus.frame_start   <= 1'b0;
            bus.locked        <= 1'b0;
            bus.lock_loss_cnt <= 8'd0;
        end else begin
            bus.pixel_out     <= act & pix_d;
            bus.x_pos         <= x_val;
            bus.y_pos         <= y_val;
            bus.active        <= act;
            bus.frame_start   <= act && (x_val == 10'd0) && (y_val == 10'd0);
            bus.locked        <= (state == ST_LOCKED);
            bus.lock_loss_cnt <= loss_cnt;
        end
    end

    assign bus.fsm_state = state;
endmodule

// File: tb/tb_vga_timing_receiver.sv
// Bench for vga_timing_receiver using a reduced raster so whole frames fit
// in a short run; the runaway-line limit (1023) is unchanged.
module tb_vga_timing_receiver;
  localparam int T_H_SYNC = 4;
  localparam int T_H_BACK = 8;
  localparam int T_H_ACTIVE = 40;
  localparam int T_H_TOTAL = 60;
  localparam int T_V_ACTIVE = 20;
  localparam int T_V_BACK = 3;
  localparam int T_V_TOTAL = 26;
  localparam int T_LOCK = 2;
  localparam int EXP_W = 32;
  localparam int X0 = T_H_SYNC + T_H_BACK;

  logic video_clk = 1'b0;
  logic reset;
  vga_timing_receiver_if bus ();

  vga_timing_receiver #(
    .H_ACTIVE(T_H_ACTIVE), .H_BACK(T_H_BACK), .H_SYNC(T_H_SYNC), .H_TOTAL(T_H_TOTAL),
    .V_ACTIVE(T_V_ACTIVE), .V_BACK(T_V_BACK), .V_TOTAL(T_V_TOTAL), .LOCK_FRAMES(T_LOCK)
  ) dut (
    .video_clk(video_clk),
    .reset(reset),
    .bus(bus)
  );

  // clock
  always #5 video_clk = ~video_clk;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  // reference model: raster position, lock status (0 search, 1 verify, 2 locked)
  int m_state, m_good, m_loss, m_h, m_v;
  int last_len, last_frame_lines;
  bit bad_in_frame;

  // observation counters for directed checks
  int pix_hits, fs_cnt;
  logic [9:0] last_x, last_y;

  function automatic logic [EXP_W-1:0] obs_vec();
    return {bus.pixel_out, bus.x_pos, bus.y_pos, bus.active, bus.frame_start,
            bus.locked, bus.lock_loss_cnt};
  endfunction

  task automatic model_reset();
    m_state = 0; m_good = 0; m_loss = 0; m_h = 0; m_v = 0;
    last_len = T_H_TOTAL; last_frame_lines = T_V_TOTAL; bad_in_frame = 0;
  endtask

  // One sample of the link: ls = first clock of a line, fs = first clock of a frame.
  task automatic model_step(input bit ls, input bit fs, input logic pix);
    bit line_bad, frame_bad, vis, act, lk, efs;
    int ex, ey;
    line_bad = ls && (last_len != T_H_TOTAL);
    frame_bad = fs && ((last_frame_lines != T_V_TOTAL) || bad_in_frame || line_bad);
    if (fs) bad_in_frame = 0;
    else if (line_bad) bad_in_frame = 1;
    m_h = ls ? 0 : ((m_h < 1023) ? m_h + 1 : 1023);
    if (fs) m_v = 0;
    else if (ls) m_v = (m_v < 1023) ? m_v + 1 : 1023;
    if (m_h == 1023 && m_state != 0) begin
      if (m_state == 2 && m_loss < 255) m_loss++;
      m_state = 0;
    end else if (m_state == 0) begin
      if (fs) begin m_state = 1; m_good = 0; end
    end else if (m_state == 1) begin
      if (fs) begin
        m_good = frame_bad ? 0 : m_good + 1;
        if (m_good >= T_LOCK) m_state = 2;
      end
    end else begin
      if (line_bad || frame_bad) begin
        m_state = 0;
        if (m_loss < 255) m_loss++;
      end
    end
    vis = (m_h >= X0) && (m_h <= X0 + T_H_ACTIVE - 1) &&
          (m_v >= T_V_BACK + 1) && (m_v <= T_V_BACK + T_V_ACTIVE);
    lk = (m_state == 2);
    act = vis && lk;
    ex = act ? m_h - X0 : 0;
    ey = act ? m_v - T_V_BACK - 1 : 0;
    efs = act && ex == 0 && ey == 0;
    exp_q.push_back({act & pix, 10'(ex), 10'(ey), act, efs, lk, 8'(m_loss)});
  endtask

  // driver
  task automatic drive(input logic hs, input logic vs, input logic pix, input bit ls, input bit fs);
    @(posedge video_clk);
    #2;
    reset = 1'b0;
    bus.hsync = hs;
    bus.vsync = vs;
    bus.pixel_in = pix;
    model_step(ls, fs, pix);
  endtask

  // pmode 0: random pixels, 1: single pixel at (5,7), 2: all zero
  task automatic send_line(input int vline, input int len, input int pmode);
    logic pix;
    for (int h = 0; h < len; h++) begin
      if (pmode == 0) pix = 1'($urandom_range(0, 1));
      else if (pmode == 1) pix = (h == X0 + 5) && (vline == T_V_BACK + 1 + 7);
      else pix = 1'b0;
      drive(h >= T_H_SYNC, vline >= 2, pix, h == 0, h == 0 && vline == 0);
    end
    last_len = len;
  endtask

  task automatic send_frame(input int lines, input int short_idx, input int pmode);
    for (int v = 0; v < lines; v++)
      send_line(v, (v == short_idx) ? T_H_TOTAL - 1 : T_H_TOTAL, pmode);
    last_frame_lines = lines;
  endtask

  task automatic send_stuck(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    last_len = last_len + n;
  endtask

  // scoreboard: outputs seen after edge k belong to the sample taken at k-1
  always @(negedge video_clk) begin
    if (exp_q.size() >= 3) begin
      logic [EXP_W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL scoreboard @%0t: got %h expected %h (pix,x,y,act,fs,lk,loss)", $time, obs_vec(), e);
      end
    end
  end

  // monitor
  always @(negedge video_clk) begin
    if (bus.pixel_out === 1'b1) begin
      pix_hits++;
      last_x = bus.x_pos;
      last_y = bus.y_pos;
    end
    if (bus.frame_start === 1'b1) fs_cnt++;
  end

  task automatic test_reset();
    reset = 1'b1;
    bus.hsync = 1'b1;
    bus.vsync = 1'b1;
    bus.pixel_in = 1'b0;
    repeat (3) @(posedge video_clk);
    @(negedge video_clk);
    checks++;
    if (obs_vec() !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs_vec()); end
    checks++;
    if (bus.fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.fsm_state); end
    model_reset();
  endtask

  task automatic test_lock();
    send_frame(T_V_TOTAL, -1, 0);
    send_frame(T_V_TOTAL, -1, 0);
    @(negedge video_clk);
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL early_lock: got %b expected 0", bus.locked); end
    send_frame(T_V_TOTAL, -1, 0);
    @(negedge video_clk);
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock: got %b expected 1", bus.locked); end
    checks++;
    if (bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL lock_loss0: got %0d expected 0", bus.lock_loss_cnt); end
  endtask

  task automatic test_pixel_position();
    pix_hits = 0; fs_cnt = 0;
    send_frame(T_V_TOTAL, -1, 1);
    @(negedge video_clk);
    checks++;
    if (pix_hits != 1) begin errors++; $display("FAIL pixel_hits: got %0d expected 1", pix_hits); end
    checks++;
    if (last_x !== 10'd5 || last_y !== 10'd7) begin errors++; $display("FAIL pixel_xy: got (%0d,%0d) expected (5,7)", last_x, last_y); end
    checks++;
    if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count: got %0d expected 1", fs_cnt); end
  endtask

  task automatic test_short_line();
    send_frame(T_V_TOTAL, 5, 0);
    @(negedge video_clk);
    checks++;
    if (bus.locked !== 1'b0 || bus.active !== 1'b0) begin errors++; $display("FAIL short_line_drop: got locked=%b active=%b expected 0,0", bus.locked, bus.active); end
    checks++;
    if (bus.lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL short_line_loss: got %0d expected 1", bus.lock_loss_cnt); end
    send_frame(T_V_TOTAL, -1, 0);
    send_frame(T_V_TOTAL, -1, 0);
    @(negedge video_clk);
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL short_line_early_relock: got %b expected 0", bus.locked); end
    send_frame(T_V_TOTAL, -1, 0);
    @(negedge video_clk);
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL short_line_relock: got %b expected 1", bus.locked); end
  endtask

  task automatic test_hsync_stuck();
    send_stuck(1100);
    @(negedge video_clk);
    checks++;
    if (bus.locked !== 1'b0 || bus.fsm_state !== 2'd0) begin errors++; $display("FAIL stuck_drop: got locked=%b state=%0d expected 0,0", bus.locked, bus.fsm_state); end
    checks++;
    if (bus.lock_loss_cnt !== 8'd2) begin errors++; $display("FAIL stuck_loss: got %0d expected 2", bus.lock_loss_cnt); end
  endtask

  task automatic test_short_frame();
    send_frame(T_V_TOTAL, -1, 0);
    send_frame(T_V_TOTAL - 1, -1, 0);
    send_frame(T_V_TOTAL, -1, 0);
    @(negedge video_clk);
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL short_frame_f3: got %b expected 0", bus.locked); end
    send_frame(T_V_TOTAL, -1, 0);
    @(negedge video_clk);
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL short_frame_f4: got %b expected 0", bus.locked); end
    send_frame(T_V_TOTAL, -1, 0);
    @(negedge video_clk);
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL short_frame_lock: got %b expected 1", bus.locked); end
  endtask

  task automatic test_reset_mid_line();
    for (int v = 0; v < 11; v++) send_line(v, T_H_TOTAL, 0);
    for (int h = 0; h < 30; h++) drive(h >= T_H_SYNC, 1'b1, 1'($urandom_range(0, 1)), h == 0, 1'b0);
    @(negedge video_clk);
    checks++;
    if (bus.active !== 1'b1) begin errors++; $display("FAIL mid_line_active: got %b expected 1", bus.active); end
    exp_q.delete();
    @(posedge video_clk);
    #2;
    reset = 1'b1;
    @(posedge video_clk);
    @(negedge video_clk);
    checks++;
    if (obs_vec() !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h expected 0", obs_vec()); end
    checks++;
    if (bus.fsm_state !== 2'd0) begin errors++; $display("FAIL mid_reset_state: got %0d expected 0", bus.fsm_state); end
    model_reset();
    last_len = T_H_TOTAL;
    for (int f = 0; f < 3; f++) send_frame(T_V_TOTAL, -1, 0);
    @(negedge video_clk);
    checks++;
    if (bus.locked !== 1'b1 || bus.lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_relock: got locked=%b loss=%0d expected 1,0", bus.locked, bus.lock_loss_cnt); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixel_position();
    test_short_line();
    test_hsync_stuck();
    test_short_frame();
    test_reset_mid_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
